// File: rtl/ltc2292_capture_ctrl.sv
// LTC2292 dual-channel ADC capture sequencer: power/wake control, trigger,
// pipeline-latency discard and fixed-length A, B or A/B interleaved streaming.
module ltc2292_capture_ctrl #(
   parameter int WIDTH       = 12,
   parameter int CNT_W       = 16,
   parameter int WAKE_CYCLES = 1000,
   parameter int DISCARD     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             trigger,
   input  logic [1:0]       chan_sel,
   input  logic [CNT_W-1:0] num_samples,
   input  logic [WIDTH-1:0] dai,
   input  logic [WIDTH-1:0] dbi,
   input  logic             ready,
   output logic             shdn,
   output logic             oe_n,
   output logic [WIDTH-1:0] data,
   output logic             data_chan,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAKE    = 3'd1;
   localparam logic [2:0] S_ARMED   = 3'd2;
   localparam logic [2:0] S_DISCARD = 3'd3;
   localparam logic [2:0] S_CAPTURE = 3'd4;

   localparam int WAKE_W = (WAKE_CYCLES < 2) ? 1 : $clog2(WAKE_CYCLES + 1);
   localparam int DISC_W = $clog2(DISCARD + 2);

   logic [2:0]        state_q, state_d;
   logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
   logic [DISC_W-1:0] disc_cnt_q, disc_cnt_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [1:0]        chan_q, chan_d;
   logic [WIDTH-1:0]  b_buf_q, b_buf_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              data_chan_q, data_chan_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic              shdn_q, shdn_d;
   logic              oe_n_q, oe_n_d;

   logic              load_word;
   logic              ovr_clr;
   logic [CNT_W-1:0]  word_idx;
   logic [1:0]        word_chan;

   always_comb begin
      state_d     = state_q;
      wake_cnt_d  = wake_cnt_q;
      disc_cnt_d  = disc_cnt_q;
      word_cnt_d  = word_cnt_q;
      num_d       = num_q;
      chan_d      = chan_q;
      b_buf_d     = b_buf_q;
      data_d      = data_q;
      data_chan_d = data_chan_q;
      done_d      = 1'b0;
      load_word   = 1'b0;
      ovr_clr     = 1'b0;
      word_idx    = word_cnt_q;
      word_chan   = chan_q;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d    = S_WAKE;
               wake_cnt_d = '0;
            end
         end
         S_WAKE: begin
            if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) state_d = S_ARMED;
            else wake_cnt_d = wake_cnt_q + 1'b1;
         end
         S_ARMED: begin
            if (trigger) begin
               num_d   = num_samples;
               chan_d  = chan_sel;
               ovr_clr = 1'b1;
               if (num_samples == '0 || chan_sel == 2'b00) begin
                  done_d = 1'b1;
               end else if (DISCARD == 0) begin
                  state_d   = S_CAPTURE;
                  load_word = 1'b1;
                  word_idx  = '0;
                  word_chan = chan_sel;
               end else begin
                  state_d    = S_DISCARD;
                  disc_cnt_d = '0;
               end
            end
         end
         S_DISCARD: begin
            if (disc_cnt_q == DISC_W'(DISCARD - 1)) begin
               state_d   = S_CAPTURE;
               load_word = 1'b1;
               word_idx  = '0;
            end else begin
               disc_cnt_d = disc_cnt_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            // word_cnt counts words already presented; equal to the target means the last one is on the bus now
            if (word_cnt_q == num_q) begin
               state_d = S_ARMED;
               done_d  = 1'b1;
            end else begin
               load_word = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Dropping enable aborts from any powered state, overriding trigger and completion
      if (!enable && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         done_d    = 1'b0;
         load_word = 1'b0;
         ovr_clr   = 1'b0;
      end

      if (load_word) begin
         word_cnt_d = word_idx + 1'b1;
         case (word_chan)
            2'b01: begin
               data_d      = dai;
               data_chan_d = 1'b0;
            end
            2'b10: begin
               data_d      = dbi;
               data_chan_d = 1'b1;
            end
            2'b11: begin
               if (!word_idx[0]) begin
                  data_d      = dai;
                  data_chan_d = 1'b0;
                  b_buf_d     = dbi;
               end else begin
                  data_d      = b_buf_q;
                  data_chan_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      overrun_d = (overrun_q & ~ovr_clr) | (valid_q & ~ready);
      valid_d   = (state_d == S_CAPTURE);
      busy_d    = (state_d == S_CAPTURE) || (state_d == S_DISCARD);
      shdn_d    = (state_d == S_IDLE);
      oe_n_d    = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wake_cnt_q  <= '0;
         disc_cnt_q  <= '0;
         word_cnt_q  <= '0;
         num_q       <= '0;
         chan_q      <= '0;
         b_buf_q     <= '0;
         data_q      <= '0;
         data_chan_q <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         shdn_q      <= 1'b1;
         oe_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         wake_cnt_q  <= wake_cnt_d;
         disc_cnt_q  <= disc_cnt_d;
         word_cnt_q  <= word_cnt_d;
         num_q       <= num_d;
         chan_q      <= chan_d;
         b_buf_q     <= b_buf_d;
         data_q      <= data_d;
         data_chan_q <= data_chan_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
         shdn_q      <= shdn_d;
         oe_n_q      <= oe_n_d;
      end
   end

   assign shdn      = shdn_q;
   assign oe_n      = oe_n_q;
   assign data      = data_q;
   assign data_chan = data_chan_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_ltc2292_capture_ctrl.sv
// Bench for ltc2292_capture_ctrl: timeline-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ltc2292_capture_ctrl;

   localparam int WIDTH = 12;
   localparam int CNT_W = 16;
   localparam int WAKE  = 4;
   localparam int DISC  = 5;
   localparam int MAXC  = 8192;

   logic             clk = 1'b0;
   logic             rst, enable, trigger, ready;
   logic [1:0]       chan_sel;
   logic [CNT_W-1:0] num_samples;
   logic [WIDTH-1:0] dai, dbi;
   logic             shdn, oe_n, data_chan, valid, busy, done, overrun;
   logic [WIDTH-1:0] data;

   always #5 clk = ~clk;

   ltc2292_capture_ctrl #(
      .WIDTH(WIDTH), .CNT_W(CNT_W), .WAKE_CYCLES(WAKE), .DISCARD(DISC)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .trigger(trigger),
      .chan_sel(chan_sel), .num_samples(num_samples), .dai(dai), .dbi(dbi),
      .ready(ready), .shdn(shdn), .oe_n(oe_n), .data(data),
      .data_chan(data_chan), .valid(valid), .busy(busy), .done(done),
      .overrun(overrun)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit ramp   = 0;
   int base   = 0;

   logic [WIDTH-1:0] dai_h [MAXC];
   logic [WIDTH-1:0] dbi_h [MAXC];

   // Model state: capture described as a trigger timestamp plus length
   bit               powered = 0;
   int               armed_from = 0;
   int               cap_t = -1;
   int               cap_n = 0;
   logic [1:0]       cap_chan = 2'b00;
   logic             e_shdn = 1, e_valid = 0, e_busy = 0, e_done = 0, e_ovr = 0, e_chan = 0;
   logic [WIDTH-1:0] e_data = '0;

   int obs_cyc[$];
   int obs_data[$];
   int obs_chan[$];
   int done_cycs[$];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
      if (ramp) begin
         dai = WIDTH'(32'h100 + (cyc - base));
         dbi = WIDTH'(32'h200 + (cyc - base));
      end else begin
         dai = WIDTH'($urandom);
         dbi = WIDTH'($urandom);
      end
   endtask

   task automatic clear_obs();
      obs_cyc.delete();
      obs_data.delete();
      obs_chan.delete();
      done_cycs.delete();
   endtask

   always @(posedge clk) begin
      int c, rel, k, sc;
      logic ovr_n, done_n, valid_n, busy_n;
      c = cyc;
      if (c < MAXC) begin
         dai_h[c] = dai;
         dbi_h[c] = dbi;
      end
      if (rst) begin
         powered = 0;
         cap_t   = -1;
         e_shdn  = 1; e_valid = 0; e_busy = 0; e_done = 0; e_ovr = 0;
         e_data  = '0; e_chan = 0;
      end else begin
         ovr_n  = e_ovr | (e_valid & ~ready);
         done_n = 0;
         if (!powered) begin
            if (enable) begin
               powered    = 1;
               armed_from = c + 1 + WAKE;
            end
         end else if (!enable) begin
            powered = 0;
            cap_t   = -1;
         end else if (cap_t < 0 && c >= armed_from && trigger) begin
            ovr_n = 0;
            if (num_samples == 0 || chan_sel == 2'b00) done_n = 1;
            else begin
               cap_t    = c;
               cap_n    = int'(num_samples);
               cap_chan = chan_sel;
            end
         end
         valid_n = 0;
         busy_n  = 0;
         if (cap_t >= 0) begin
            rel = c + 1 - cap_t - DISC;
            if (rel <= cap_n) busy_n = 1;
            if (rel >= 1 && rel <= cap_n) begin
               valid_n = 1;
               k = rel - 1;
               if (cap_chan == 2'b11) begin
                  sc = cap_t + DISC + 2 * (k / 2);
                  e_data = (k % 2 == 0) ? dai_h[sc] : dbi_h[sc];
                  e_chan = (k % 2 == 1);
               end else begin
                  sc = cap_t + DISC + k;
                  e_data = (cap_chan == 2'b01) ? dai_h[sc] : dbi_h[sc];
                  e_chan = (cap_chan == 2'b10);
               end
            end
            if (rel == cap_n + 1) begin
               done_n = 1;
               cap_t  = -1;
            end
         end
         e_shdn  = !powered;
         e_valid = valid_n;
         e_busy  = busy_n;
         e_done  = done_n;
         e_ovr   = ovr_n;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         check_output("shdn", shdn, e_shdn);
         check_output("oe_n", oe_n, e_shdn);
         check_output("valid", valid, e_valid);
         check_output("busy", busy, e_busy);
         check_output("done", done, e_done);
         check_output("overrun", overrun, e_ovr);
         if (e_valid) begin
            check_output("data", data, e_data);
            check_output("data_chan", data_chan, e_chan);
         end
         if (valid) begin
            obs_cyc.push_back(cyc);
            obs_data.push_back(int'(data));
            obs_chan.push_back(int'(data_chan));
         end
         if (done) done_cycs.push_back(cyc);
      end
   end

   initial begin
      int e, t, rise, n0;
      int exp_ab[5];
      rst = 1; enable = 0; trigger = 0; chan_sel = 2'b00; num_samples = '0;
      ready = 1; dai = '0; dbi = '0;
      exp_ab = '{32'h105, 32'h205, 32'h107, 32'h207, 32'h109};
      repeat (3) next_cycle();
      check_output("rst_shdn", shdn, 1);
      check_output("rst_oe_n", oe_n, 1);
      check_output("rst_data", data, 0);
      check_output("rst_valid", valid, 0);
      check_output("rst_overrun", overrun, 0);
      check_output("rst_busy", busy, 0);
      rst = 0;
      next_cycle();

      // Wake timing, then a single-channel ramp capture
      e = cyc; base = e + 5; ramp = 1;
      enable = 1; trigger = 1; chan_sel = 2'b01; num_samples = 16'd8;
      clear_obs();
      next_cycle();
      check_output("t1_shdn_fall", shdn, 0);
      rise = -1;
      for (int i = 0; i < 30; i++) begin
         if (busy) begin rise = cyc; break; end
         next_cycle();
      end
      trigger = 0;
      check_output("t1_arm_latency", rise - e, 6);
      repeat (16) next_cycle();
      check_output("t2_word_count", obs_cyc.size(), 8);
      if (obs_cyc.size() == 8) begin
         check_output("t2_first_valid", obs_cyc[0] - (e + 5), 6);
         for (int i = 0; i < 8; i++) begin
            check_output("t2_ramp_data", obs_data[i], 32'h105 + i);
            check_output("t2_chan", obs_chan[i], 0);
         end
         check_output("t2_done_count", done_cycs.size(), 1);
         if (done_cycs.size() == 1) check_output("t2_done_time", done_cycs[0], obs_cyc[7] + 1);
      end

      // A/B interleaved, odd length
      clear_obs();
      t = cyc; base = t;
      chan_sel = 2'b11; num_samples = 16'd5; trigger = 1;
      next_cycle();
      trigger = 0;
      repeat (14) next_cycle();
      check_output("t3_word_count", obs_cyc.size(), 5);
      if (obs_cyc.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            check_output("t3_ab_data", obs_data[i], exp_ab[i]);
            check_output("t3_ab_chan", obs_chan[i], i % 2);
         end
      end
      check_output("t3_done_count", done_cycs.size(), 1);
      if (done_cycs.size() == 1) check_output("t3_done_time", done_cycs[0] - t, 11);

      // Backpressure sets sticky overrun; a zero-length trigger clears it
      clear_obs();
      t = cyc; chan_sel = 2'b01; num_samples = 16'd10; trigger = 1;
      next_cycle();
      trigger = 0;
      while (cyc < t + 8) next_cycle();
      ready = 0;
      next_cycle();
      ready = 1;
      check_output("t4_overrun_set", overrun, 1);
      while (cyc < t + 20) next_cycle();
      check_output("t4_word_count", obs_cyc.size(), 10);
      check_output("t4_overrun_hold", overrun, 1);
      if (done_cycs.size() == 1) check_output("t4_done_time", done_cycs[0] - t, 16);
      else check_output("t4_done_count", done_cycs.size(), 1);
      trigger = 1; num_samples = '0;
      next_cycle();
      trigger = 0;
      check_output("t6_zero_done", done, 1);
      check_output("t6_zero_valid", valid, 0);
      check_output("t4_overrun_clear", overrun, 0);

      // Abort on the third word, then full wake before re-arm
      next_cycle();
      clear_obs();
      t = cyc; num_samples = 16'd8; trigger = 1;
      next_cycle();
      trigger = 0;
      while (cyc < t + 8) next_cycle();
      check_output("t5_third_word_valid", valid, 1);
      enable = 0;
      next_cycle();
      check_output("t5_abort_valid", valid, 0);
      check_output("t5_abort_shdn", shdn, 1);
      next_cycle();
      e = cyc; enable = 1; trigger = 1;
      check_output("t5_no_done", done_cycs.size(), 0);
      rise = -1;
      for (int i = 0; i < 30; i++) begin
         if (busy) begin rise = cyc; break; end
         next_cycle();
      end
      trigger = 0;
      check_output("t5_rearm_latency", rise - e, 6);
      repeat (16) next_cycle();

      // Trigger during capture is ignored
      clear_obs();
      t = cyc; num_samples = 16'd8; trigger = 1;
      next_cycle();
      trigger = 0;
      while (cyc < t + 9) next_cycle();
      trigger = 1; num_samples = 16'd3;
      next_cycle();
      trigger = 0;
      while (cyc < t + 20) next_cycle();
      n0 = obs_cyc.size();
      check_output("t6_word_count", n0, 8);
      check_output("t6_done_count", done_cycs.size(), 1);

      // Randomized traffic against the model
      ramp = 0;
      for (int i = 0; i < 3000; i++) begin
         next_cycle();
         rst         = ($urandom_range(0, 499) == 0);
         enable      = ($urandom_range(0, 299) != 0);
         trigger     = ($urandom_range(0, 15) == 0);
         chan_sel    = 2'($urandom_range(0, 3));
         num_samples = CNT_W'($urandom_range(0, 12));
         ready       = ($urandom_range(0, 9) != 0);
      end
      rst = 0; trigger = 0; ready = 1;
      repeat (30) next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
